// File: rtl/hps_frame_pkg.sv
// Shared types and constants for the HPS frame sequencer.
//   state_t : frame sequencer states (IDLE, CMD, DATA, ERR)
//   chan_t  : which client owns the open frame (none, core IO, OSD)
//   IDLE_RESP_DEF : response word driven when no frame is open
//   ERR_CNT_W     : width of the saturating protocol error counter
package hps_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CH_NONE = 2'd0,
        CH_IO   = 2'd1,
        CH_OSD  = 2'd2
    } chan_t;

    localparam logic [15:0] IDLE_RESP_DEF = 16'h0000;
    localparam int          ERR_CNT_W     = 8;

endpackage

// File: rtl/hps_frame_watchdog.sv
// Frame watchdog: counts cycles without a word strobe while a frame is open.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (word strobe, or no frame open)
//   en         : count this cycle (frame open)
//   tc         : terminal count, high in the (2^TO_W-1)-th counted cycle
//                since the last clear; never high when TO_EN = 0
module hps_frame_watchdog #(
    parameter int TO_W  = 20,
    parameter bit TO_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // The count holds the number of cycles already counted, so the cycle
    // that would be number 2^TO_W-1 sees count == 2^TO_W-2.
    localparam logic [TO_W-1:0] LAST = {TO_W{1'b1}} - TO_W'(1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = TO_EN && en && !clr && (count == LAST);

endmodule

// File: rtl/hps_frame_sequencer.sv
// Frames the HPS SPI word stream into command + payload words and shares the
// single word channel between the core IO client and the OSD client.
//   sys_clk, reset_n      : clock, asynchronous active-low reset
//   hps_word, hps_strobe  : received SPI word and its one-cycle strobe
//   fpga_en               : master enable, low aborts any open frame
//   io_en, osd_en         : client frame enables (levels)
//   hps_resp              : response word back to the SPI slave
//   cmd, din, idx         : frame command, payload word and payload index
//   io_*/osd_* strobes    : per-client command / payload / frame-end pulses
//   io_dout, osd_dout     : client response words
//   frame_abort, frame_err, err_cnt : abort pulse, error pulse, error count
// All outputs are registered one cycle after the input that causes them.
module hps_frame_sequencer
    import hps_frame_pkg::*;
#(
    parameter int          IDX_W     = 12,
    parameter int          TO_W      = 20,
    parameter bit          TO_EN     = 1'b1,
    parameter logic [15:0] IDLE_RESP = IDLE_RESP_DEF
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic [15:0]          hps_word,
    input  logic                 hps_strobe,
    input  logic                 fpga_en,
    input  logic                 io_en,
    input  logic                 osd_en,
    output logic [15:0]          hps_resp,
    output logic [15:0]          cmd,
    output logic [15:0]          din,
    output logic [IDX_W-1:0]     idx,
    output logic                 io_cmd_stb,
    output logic                 io_din_stb,
    output logic                 io_end,
    output logic                 osd_cmd_stb,
    output logic                 osd_din_stb,
    output logic                 osd_end,
    input  logic [15:0]          io_dout,
    input  logic [15:0]          osd_dout,
    output logic                 frame_abort,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    function automatic logic [IDX_W-1:0] sat_inc_idx(input logic [IDX_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t               state, state_nxt;
    chan_t                chan, chan_nxt;
    logic [IDX_W-1:0]     cnt, cnt_nxt;
    logic [15:0]          cmd_nxt, din_nxt, resp_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 cmd_stb_nxt, din_stb_nxt, end_nxt, abort_nxt, err_nxt;
    logic [ERR_CNT_W-1:0] err_cnt_nxt;
    logic                 own_en, other_en, in_frame, wd_tc;

    assign in_frame = (state == ST_CMD) || (state == ST_DATA);

    hps_frame_watchdog #(
        .TO_W  (TO_W),
        .TO_EN (TO_EN)
    ) u_watchdog (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .clr   (hps_strobe || !in_frame),
        .en    (in_frame),
        .tc    (wd_tc)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            chan  <= CH_NONE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            chan  <= chan_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        chan_nxt    = chan;
        cnt_nxt     = cnt;
        cmd_nxt     = cmd;
        din_nxt     = din;
        idx_nxt     = idx;
        cmd_stb_nxt = 1'b0;
        din_stb_nxt = 1'b0;
        end_nxt     = 1'b0;
        abort_nxt   = 1'b0;
        own_en      = (chan == CH_IO) ? io_en  : osd_en;
        other_en    = (chan == CH_IO) ? osd_en : io_en;

        if (!fpga_en) begin
            // Master enable overrides everything, including a pending strobe.
            state_nxt = ST_IDLE;
            if (in_frame) begin
                end_nxt   = 1'b1;
                abort_nxt = 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_en && osd_en) begin
                        state_nxt = ST_ERR;
                    end else if (io_en) begin
                        state_nxt = ST_CMD;
                        chan_nxt  = CH_IO;
                    end else if (osd_en) begin
                        state_nxt = ST_CMD;
                        chan_nxt  = CH_OSD;
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (other_en) begin
                        end_nxt   = 1'b1;
                        state_nxt = ST_ERR;
                    end else if (wd_tc) begin
                        end_nxt   = 1'b1;
                        abort_nxt = 1'b1;
                        state_nxt = ST_ERR;
                    end else if (state == ST_CMD) begin
                        // An enable drop before the command word is an empty frame.
                        if (!own_en) begin
                            state_nxt = ST_IDLE;
                        end else if (hps_strobe) begin
                            cmd_nxt     = hps_word;
                            cmd_stb_nxt = 1'b1;
                            idx_nxt     = '0;
                            cnt_nxt     = '0;
                            state_nxt   = ST_DATA;
                        end
                    end else begin
                        // A word arriving with the enable drop is still delivered.
                        if (hps_strobe) begin
                            din_nxt     = hps_word;
                            din_stb_nxt = 1'b1;
                            idx_nxt     = cnt;
                            cnt_nxt     = sat_inc_idx(cnt);
                        end
                        if (!own_en) begin
                            end_nxt   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    if (!io_en && !osd_en) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        err_nxt     = (state_nxt == ST_ERR) && (state != ST_ERR);
        err_cnt_nxt = err_nxt ? sat_inc_err(err_cnt) : err_cnt;
        resp_nxt    = !in_frame ? IDLE_RESP : ((chan == CH_IO) ? io_dout : osd_dout);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hps_resp    <= IDLE_RESP;
            cmd         <= '0;
            din         <= '0;
            idx         <= '0;
            io_cmd_stb  <= 1'b0;
            io_din_stb  <= 1'b0;
            io_end      <= 1'b0;
            osd_cmd_stb <= 1'b0;
            osd_din_stb <= 1'b0;
            osd_end     <= 1'b0;
            frame_abort <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            hps_resp    <= resp_nxt;
            cmd         <= cmd_nxt;
            din         <= din_nxt;
            idx         <= idx_nxt;
            io_cmd_stb  <= cmd_stb_nxt && (chan == CH_IO);
            io_din_stb  <= din_stb_nxt && (chan == CH_IO);
            io_end      <= end_nxt     && (chan == CH_IO);
            osd_cmd_stb <= cmd_stb_nxt && (chan == CH_OSD);
            osd_din_stb <= din_stb_nxt && (chan == CH_OSD);
            osd_end     <= end_nxt     && (chan == CH_OSD);
            frame_abort <= abort_nxt;
            frame_err   <= err_nxt;
            err_cnt     <= err_cnt_nxt;
        end
    end

endmodule
